// File: rtl/conv_capture_path.sv
// Camera capture path: RGB444 byte-pair assembly, optional 3x3 convolution,
// and a single-frame pixel buffer with a registered read-first VGA port.
module conv_capture_path #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19,
    parameter int DW    = 12
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          pclk_cam,
    input  logic          vsync_cam,
    input  logic          href_cam,
    input  logic [7:0]    wdata_cam,
    input  logic          pass_thru,
    input  logic [1:0]    kernel_select,
    input  logic [AW-1:0] raddr_vga,
    output logic [DW-1:0] rdata_vga
);

    localparam int DEPTH = H_RES * V_RES;
    localparam int XW    = $clog2(H_RES + 1);
    localparam int YW    = $clog2(V_RES + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_RES);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES);
    localparam logic [AW-1:0] ROW   = AW'(H_RES);

    // Coefficients are 5-bit so the edge kernel's +8 centre is representable.
    function automatic logic [4:0] kcoef(input logic [1:0] sel,
                                         input logic [3:0] t);
        logic ctr;
        logic edg;
        ctr   = (t == 4'd4);
        edg   = t[0];
        kcoef = 5'd0;
        unique case (sel)
            2'd0: kcoef = ctr ? 5'd1 : 5'd0;
            2'd1: kcoef = ctr ? 5'd4 : (edg ? 5'd2 : 5'd1);
            2'd2: kcoef = ctr ? 5'd5 : (edg ? 5'h1f : 5'd0);
            2'd3: kcoef = ctr ? 5'd8 : 5'h1f;
        endcase
    endfunction

    function automatic logic [2:0] kdiv(input logic [1:0] sel);
        kdiv = (sel == 2'd1) ? 3'd4 : 3'd0;
    endfunction

    logic          pclk_s1_q, pclk_s2_q, pclk_p_q;
    logic          href_s1_q, href_s2_q, href_p_q;
    logic          vs_s1_q, vs_s2_q, vs_p_q;
    logic [7:0]    dat_s1_q, dat_s2_q;

    logic          armed_q, armed_d;
    logic          phase_q, phase_d;
    logic [3:0]    byte0_q, byte0_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] base_q, base_d;
    logic          mpt_q, mpt_d;
    logic [1:0]    mks_q, mks_d;

    logic [2:0][2:0][DW-1:0] win_q, win_d;
    logic          v1_q, v1_d;
    logic [AW-1:0] a1_q, a1_d;
    logic          v2_q, v2_d;
    logic [AW-1:0] a2_q, a2_d;
    logic [2:0][8:0][9:0] prod_q, prod_d;

    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [DW-1:0] lb1 [H_RES];
    logic [DW-1:0] lb2 [H_RES];
    logic [DW-1:0] fb  [DEPTH];

    logic          strobe, vs_rise, href_fall;
    logic          in_range, pix_ok, we_pt;
    logic [DW-1:0] pix, lb1_rd, lb2_rd, conv_px;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pclk_s1_q <= 1'b0;
            pclk_s2_q <= 1'b0;
            pclk_p_q  <= 1'b0;
            href_s1_q <= 1'b0;
            href_s2_q <= 1'b0;
            href_p_q  <= 1'b0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_p_q    <= 1'b0;
            dat_s1_q  <= '0;
            dat_s2_q  <= '0;
        end else begin
            pclk_s1_q <= pclk_cam;
            pclk_s2_q <= pclk_s1_q;
            pclk_p_q  <= pclk_s2_q;
            href_s1_q <= href_cam;
            href_s2_q <= href_s1_q;
            href_p_q  <= href_s2_q;
            vs_s1_q   <= vsync_cam;
            vs_s2_q   <= vs_s1_q;
            vs_p_q    <= vs_s2_q;
            dat_s1_q  <= wdata_cam;
            dat_s2_q  <= dat_s1_q;
        end
    end

    always_comb begin
        strobe    = pclk_s2_q & ~pclk_p_q;
        vs_rise   = vs_s2_q & ~vs_p_q;
        href_fall = href_p_q & ~href_s2_q;
        pix       = {byte0_q, dat_s2_q};
        in_range  = (x_q < X_MAX) && (y_q < Y_MAX);
        pix_ok    = armed_q & ~vs_rise & strobe & href_s2_q & phase_q
                  & in_range & ~rst;
        lb1_rd    = lb1[x_q];
        lb2_rd    = lb2[x_q];

        armed_d = armed_q;
        phase_d = phase_q;
        byte0_d = byte0_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        mpt_d   = mpt_q;
        mks_d   = mks_q;
        win_d   = win_q;
        v1_d    = 1'b0;
        a1_d    = a1_q;
        v2_d    = v1_q;
        a2_d    = a1_q;
        we_pt   = 1'b0;

        if (vs_rise) begin
            armed_d = 1'b1;
            phase_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
            base_d  = '0;
            mpt_d   = pass_thru;
            mks_d   = kernel_select;
        end else if (armed_q) begin
            if (!href_s2_q) phase_d = 1'b0;
            if (href_fall && x_q != '0) begin
                x_d = '0;
                if (y_q < Y_MAX) begin
                    y_d    = y_q + YW'(1);
                    base_d = base_q + ROW;
                end
            end
            if (strobe && href_s2_q) begin
                phase_d = ~phase_q;
                if (!phase_q) byte0_d = dat_s2_q[3:0];
                else if (x_q < X_MAX) x_d = x_q + XW'(1);
            end
        end

        // Window columns shift left; the new right column is rows y-2, y-1, y.
        if (pix_ok) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = {pix, lb1_rd, lb2_rd};
            v1_d     = ~mpt_q && (x_q >= XW'(2)) && (y_q >= YW'(2));
            a1_d     = base_q - ROW + AW'(x_q) - AW'(1);
            we_pt    = mpt_q;
        end

        we_d    = we_pt | v2_q;
        waddr_d = we_pt ? base_q + AW'(x_q) : a2_q;
        wdata_d = we_pt ? pix : conv_px;
        rdata_d = (raddr_vga < AW'(DEPTH)) ? fb[raddr_vga] : '0;
    end

    always_comb begin : p_mul
        logic [3:0]        smp;
        logic [4:0]        k;
        logic signed [9:0] a;
        logic signed [9:0] b;
        smp    = '0;
        k      = '0;
        a      = '0;
        b      = '0;
        prod_d = prod_q;
        for (int ch = 0; ch < 3; ch++) begin
            for (int t = 0; t < 9; t++) begin
                smp = win_q[t % 3][t / 3][ch*4 +: 4];
                k   = kcoef(mks_q, 4'(t));
                a   = $signed({6'b0, smp});
                b   = $signed({{5{k[4]}}, k});
                prod_d[ch][t] = a * b;
            end
        end
    end

    always_comb begin : p_sum
        logic [11:0]        acc;
        logic signed [11:0] sh;
        acc     = '0;
        sh      = '0;
        conv_px = '0;
        for (int ch = 0; ch < 3; ch++) begin
            acc = '0;
            for (int t = 0; t < 9; t++)
                acc = acc + {{2{prod_q[ch][t][9]}}, prod_q[ch][t]};
            sh = $signed(acc) >>> kdiv(mks_q);
            if (sh[11])         conv_px[ch*4 +: 4] = 4'h0;
            else if (|sh[10:4]) conv_px[ch*4 +: 4] = 4'hf;
            else                conv_px[ch*4 +: 4] = sh[3:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            phase_q <= 1'b0;
            byte0_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            mpt_q   <= pass_thru;
            mks_q   <= kernel_select;
            win_q   <= '0;
            v1_q    <= 1'b0;
            a1_q    <= '0;
            v2_q    <= 1'b0;
            a2_q    <= '0;
            prod_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            armed_q <= armed_d;
            phase_q <= phase_d;
            byte0_q <= byte0_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            mpt_q   <= mpt_d;
            mks_q   <= mks_d;
            win_q   <= win_d;
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            v2_q    <= v2_d;
            a2_q    <= a2_d;
            prod_q  <= prod_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (pix_ok) begin
            lb2[x_q] <= lb1_rd;
            lb1[x_q] <= pix;
        end
        if (we_q && !rst) fb[waddr_q] <= wdata_q;
    end

    assign rdata_vga = rdata_q;

endmodule

// File: tb/tb_conv_capture_path.sv
// Directed bench for conv_capture_path: capture, pass-through,
// convolution kernels, frame/line boundaries and mode latching.
module tb_conv_capture_path;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        pclk_cam;
    logic        vsync_cam;
    logic        href_cam;
    logic [7:0]  wdata_cam;
    logic        pass_thru;
    logic [1:0]  kernel_select;
    logic [18:0] raddr_vga;
    logic [11:0] rdata_vga;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    conv_capture_path dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .pclk_cam      (pclk_cam),
        .vsync_cam     (vsync_cam),
        .href_cam      (href_cam),
        .wdata_cam     (wdata_cam),
        .pass_thru     (pass_thru),
        .kernel_select (kernel_select),
        .raddr_vga     (raddr_vga),
        .rdata_vga     (rdata_vga)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rd(input string tag, input int addr,
                            input logic [11:0] exp);
        raddr_vga = 19'(addr);
        tick(1);
        check(tag, 32'(rdata_vga), 32'(exp));
    endtask

    task automatic send_byte(input logic [7:0] b);
        wdata_cam = b;
        pclk_cam  = 1'b1;
        tick(2);
        pclk_cam  = 1'b0;
        tick(2);
    endtask

    task automatic send_pix(input logic [11:0] p);
        send_byte({4'h0, p[11:8]});
        send_byte(p[7:0]);
    endtask

    task automatic send_line(input int n, input logic [11:0] v);
        href_cam = 1'b1;
        tick(2);
        repeat (n) send_pix(v);
        href_cam = 1'b0;
        tick(6);
    endtask

    task automatic pulse_vsync();
        vsync_cam = 1'b1;
        tick(3);
        vsync_cam = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        rst           = 1'b1;
        pclk_cam      = 1'b0;
        vsync_cam     = 1'b0;
        href_cam      = 1'b0;
        wdata_cam     = 8'h00;
        pass_thru     = 1'b1;
        kernel_select = 2'd0;
        raddr_vga     = '0;
        tick(3);
        check("reset_rdata", 32'(rdata_vga), 32'h0);
        rst = 1'b0;
        tick(2);

        // Pass-through: byte0 high nibble ignored, then 3 short lines
        pulse_vsync();
        href_cam = 1'b1;
        tick(2);
        send_byte(8'h0A);
        send_byte(8'hBC);
        send_byte(8'hFA);
        send_byte(8'hBC);
        send_pix(12'h123);
        send_pix(12'h456);
        href_cam = 1'b0;
        tick(6);
        repeat (3) send_line(1, 12'h777);
        check_rd("pt_addr0", 0, 12'hABC);
        check_rd("pt_hi_nib", 1, 12'hABC);
        check_rd("pt_addr2", 2, 12'h123);
        check_rd("pt_addr3", 3, 12'h456);

        // Disarmed after reset: no writes without vsync
        do_reset();
        repeat (2) send_line(4, 12'hEEE);
        check_rd("unarmed0", 0, 12'hABC);
        check_rd("unarmed1", 1, 12'hABC);
        check_rd("unarmed3", 3, 12'h456);

        // Full-width lines; extra pixel on last line must be dropped
        pulse_vsync();
        for (int yy = 0; yy < 3; yy++) begin
            href_cam = 1'b1;
            tick(2);
            for (int xx = 0; xx < 640; xx++)
                send_pix(12'(yy * 640 + xx));
            if (yy == 2) send_pix(12'h999);
            href_cam = 1'b0;
            tick(6);
        end
        check_rd("lin_1000", 1000, 12'h3E8);
        check_rd("lin_640", 640, 12'h280);
        check_rd("lin_1919", 1919, 12'h77F);
        check_rd("x_drop", 1920, 12'h777);

        // Convolution on constant frames
        pass_thru     = 1'b0;
        kernel_select = 2'd3;
        pulse_vsync();
        repeat (3) send_line(4, 12'h5A3);
        check_rd("edge_641", 641, 12'h000);
        check_rd("edge_642", 642, 12'h000);

        kernel_select = 2'd1;
        pulse_vsync();
        repeat (3) send_line(4, 12'h5A3);
        check_rd("blur_641", 641, 12'h5A3);

        kernel_select = 2'd0;
        pulse_vsync();
        repeat (3) send_line(4, 12'h3C7);
        check_rd("ident_641", 641, 12'h3C7);
        check_rd("border_col0", 640, 12'h280);
        check_rd("border_row0", 1, 12'h001);

        // Sharpen: single bright pixel at (2,2) on 0x111
        kernel_select = 2'd2;
        pulse_vsync();
        for (int yy = 0; yy < 4; yy++) begin
            href_cam = 1'b1;
            tick(2);
            for (int xx = 0; xx < 4; xx++)
                send_pix((xx == 2 && yy == 2) ? 12'hFFF : 12'h111);
            href_cam = 1'b0;
            tick(6);
        end
        check_rd("sharp_hi", 1282, 12'hFFF);
        check_rd("sharp_neg21", 642, 12'h000);
        check_rd("sharp_11", 641, 12'h111);
        check_rd("sharp_neg12", 1281, 12'h000);

        // Kernel change mid-frame must not take effect
        kernel_select = 2'd0;
        pulse_vsync();
        send_line(4, 12'h246);
        kernel_select = 2'd3;
        repeat (2) send_line(4, 12'h246);
        check_rd("ks_latched", 641, 12'h246);

        // vsync mid-line (after a dangling byte) restarts at address 0
        pass_thru = 1'b1;
        pulse_vsync();
        href_cam = 1'b1;
        tick(2);
        send_pix(12'h101);
        send_byte(8'h01);
        pulse_vsync();
        send_pix(12'h201);
        send_pix(12'h202);
        href_cam = 1'b0;
        tick(6);
        check_rd("vs_mid0", 0, 12'h201);
        check_rd("vs_mid1", 1, 12'h202);
        check_rd("vs_mid2", 2, 12'h002);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
